// File: rtl/da.sv
// Bit-serial distributed-arithmetic 8-tap FIR: one LUT lookup per sample bit, 8 cycles per result.
// Optional DA_LUT_CLEAR_EN: reset also clears the 256-entry coefficient LUT.
module da (
  input  logic               clk,
  input  logic               resetn,
  input  logic signed [7:0]  A0,
  input  logic signed [7:0]  A1,
  input  logic signed [7:0]  A2,
  input  logic signed [7:0]  A3,
  input  logic signed [7:0]  A4,
  input  logic signed [7:0]  A5,
  input  logic signed [7:0]  A6,
  input  logic signed [7:0]  A7,
  input  logic               valid_in,
  input  logic               start,
  input  logic               CLOAD,
  input  logic [10:0]        CADDR,
  input  logic signed [19:0] CIN,
  output logic signed [37:0] acc,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start with valid_in; LUT writable
  // RUN   | one sample bit per cycle, b = 0..7
  // DONE  | done pulse, acc valid
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            b_q, b_d;
  logic [7:0][7:0]       smp_q, smp_d;
  logic signed [37:0]    acc_q, acc_d;
  logic signed [19:0]    lut_q [256];
  logic [7:0]            addr;
  logic signed [37:0]    term;
  logic                  accept;
  logic                  lut_we;

  assign accept = (state_q == IDLE) && start && valid_in;
  assign lut_we = CLOAD && (CADDR[10:8] == 3'b000) && (state_q == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (b_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  always_comb begin
    addr = '0;
    for (int k = 0; k < 8; k++) addr[k] = smp_q[k][b_q];
  end

  assign term = {{18{lut_q[addr][19]}}, lut_q[addr]} <<< b_q;

  always_comb begin
    b_d   = b_q;
    smp_d = smp_q;
    acc_d = acc_q;
    if (accept) begin
      b_d   = 3'd0;
      smp_d = {A7, A6, A5, A4, A3, A2, A1, A0};
      acc_d = '0;
    end else if (state_q == RUN) begin
      b_d = b_q + 3'd1;
      // the MSB of a two's-complement sample carries negative weight
      if (b_q == 3'd7) acc_d = acc_q - term;
      else             acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_q   <= '0;
      smp_q <= '0;
      acc_q <= '0;
    end else begin
      b_q   <= b_d;
      smp_q <= smp_d;
      acc_q <= acc_d;
    end
  end

`ifdef DA_LUT_CLEAR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[CADDR[7:0]] <= CIN;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (lut_we) lut_q[CADDR[7:0]] <= CIN;
  end
`endif

  assign acc = acc_q;

endmodule

// File: tb/tb_da.sv
// Randomized bench for da: compares acc against sum_k h_k * A_k computed from the tap coefficients.
module tb_da;
  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic [7:0][7:0]       a_drv = '0;
  logic                  valid_in = 1'b0;
  logic                  start = 1'b0;
  logic                  CLOAD = 1'b0;
  logic [10:0]           CADDR = '0;
  logic signed [19:0]    CIN = '0;
  logic signed [37:0]    acc;
  logic                  done;

  int n_cmp = 0;
  int n_err = 0;
  int h [8];

  da dut (
    .clk(clk), .resetn(resetn),
    .A0(a_drv[0]), .A1(a_drv[1]), .A2(a_drv[2]), .A3(a_drv[3]),
    .A4(a_drv[4]), .A5(a_drv[5]), .A6(a_drv[6]), .A7(a_drv[7]),
    .valid_in(valid_in), .start(start),
    .CLOAD(CLOAD), .CADDR(CADDR), .CIN(CIN),
    .acc(acc), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] model(input logic [63:0] s);
    logic signed [63:0] r;
    logic signed [7:0]  v;
    r = 0;
    for (int k = 0; k < 8; k++) begin
      v = s[k*8 +: 8];
      r += 64'(h[k]) * 64'(v);
    end
    return r;
  endfunction

  function automatic logic signed [19:0] lut_entry(input int a);
    int r;
    r = 0;
    for (int k = 0; k < 8; k++) if (a[k]) r += h[k];
    return 20'(r);
  endfunction

  task automatic load_lut();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      CLOAD = 1'b1;
      CADDR = {3'b000, 8'(a)};
      CIN   = lut_entry(a);
    end
    @(negedge clk);
    CLOAD = 1'b0;
  endtask

  // mode 0 plain, 1 new samples + start during RUN, 2 CLOAD during RUN/DONE, 3 start on the DONE-exit edge
  task automatic do_run(input logic [63:0] s, input int mode, output logic signed [63:0] res);
    int lat;
    int pulses;
    lat = 0;
    pulses = 0;
    res = 0;
    a_drv = s;
    valid_in = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          res = 64'(acc);
        end
      end
      start = 1'b0;
      CLOAD = 1'b0;
      if (k >= 9) valid_in = 1'b0;
      if (mode == 1 && k >= 2 && k <= 5) begin
        a_drv = {$urandom, $urandom};
        start = 1'b1;
      end
      if (mode == 2 && k <= 8) begin
        CLOAD = 1'b1;
        CADDR = {3'b000, 8'($urandom)};
        CIN   = 20'($urandom);
      end
      if (mode == 3 && k == 9) begin
        valid_in = 1'b1;
        start = 1'b1;
      end
    end
    chk("latency", lat, 9);
    chk("done_pulses", pulses, 1);
    chk("acc_hold", 64'(acc), res);
  endtask

  initial begin
    logic signed [63:0] r;
    logic signed [63:0] r_exp;
    logic [63:0]        v;
    int                 cnt;

    #12;
    chk("rst_acc", 64'(acc), 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_acc", 64'(acc), 0);

    for (int k = 0; k < 8; k++) h[k] = 1;
    load_lut();
    do_run(64'h0101010101010101, 0, r);
    chk("ones", r, 8);
    do_run(64'h8080808080808080, 0, r);
    chk("all_m128", r, -1024);
    do_run(64'h7f7f7f7f7f7f7f7f, 0, r);
    chk("all_p127", r, 1016);

    for (int k = 0; k < 8; k++) h[k] = 0;
    h[0] = 3;
    load_lut();
    do_run(64'h00000000000000ff, 0, r);
    chk("a0_minus1", r, -3);

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) h[k] = int'($urandom_range(0, 65535)) - 32768;
      load_lut();
      for (int n = 0; n < 4; n++) begin
        v = {$urandom, $urandom};
        do_run(v, 0, r);
        chk("rand", r, model(v));
      end
      v = {$urandom, $urandom};
      r_exp = model(v);
      do_run(v, 1, r);
      chk("run_perturb", r, r_exp);
      v = {$urandom, $urandom};
      do_run(v, 3, r);
      chk("start_at_done", r, model(v));
    end

    // start without valid_in must not launch a run
    cnt = 0;
    start = 1'b1;
    valid_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    start = 1'b0;
    chk("start_no_valid", cnt, 0);

    v = {$urandom, $urandom};
    r_exp = model(v);
    do_run(v, 2, r);
    chk("cload_in_run", r, r_exp);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      CLOAD = 1'b1;
      CADDR = {3'(1 + $urandom_range(0, 6)), 8'($urandom)};
      CIN   = 20'($urandom);
    end
    @(negedge clk);
    CLOAD = 1'b0;
    do_run(v, 0, r);
    chk("cload_reserved", r, r_exp);

    for (int k = 0; k < 8; k++) h[k] = 1;
    load_lut();
    a_drv = 64'h0101010101010101;
    valid_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_done", done, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_acc", 64'(acc), 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    do_run(64'h0101010101010101, 0, r);
`ifdef DA_LUT_CLEAR_EN
    r_exp = 0;
`else
    r_exp = 8;
`endif
    chk("after_rst_run", r, r_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
